// File: rtl/queue_drain_tx.sv
// Read side of the router input queue: pops valid head flits and forwards them
// onto the outbound link under credit flow control, or discards them in flush mode.
module queue_drain_tx #(
    parameter  int PL      = 8,
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1),
    parameter  int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:PL-1]    head_data,
    input  logic             enable,
    input  logic             flush,
    input  logic             link_credit,
    output logic             queue_shift,
    output logic [0:PL-1]    link_data,
    output logic [CW-1:0]    credits,
    output logic             busy,
    output logic             credit_err,
    output logic [CNT_W-1:0] flit_count
);

    localparam logic [CW-1:0] CREDITS_FULL = CW'(CREDITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             queue_shift_q, queue_shift_d;
    logic [0:PL-1]    link_data_q, link_data_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             credit_err_q, credit_err_d;
    logic [CNT_W-1:0] flit_count_q, flit_count_d;
    logic             send;
    logic             head_valid;

    assign head_valid = head_data[0];

    always_comb begin
        state_d       = state_q;
        queue_shift_d = 1'b0;
        link_data_d   = '0;
        send          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (enable) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Send decision uses the RUN state even when leaving it this edge.
                if (head_valid && (credits_q != '0)) begin
                    send          = 1'b1;
                    link_data_d   = head_data;
                    queue_shift_d = 1'b1;
                end
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (head_valid) begin
                    queue_shift_d = 1'b1;
                end else if (!flush) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        flit_count_d = flit_count_q;

        if (send) begin
            flit_count_d = flit_count_q + CNT_W'(1);
        end

        if (send && !link_credit) begin
            credits_d = credits_q - CW'(1);
        end else if (!send && link_credit) begin
            // A return into a full counter means downstream over-credited us.
            if (credits_q == CREDITS_FULL) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            queue_shift_q <= 1'b0;
            link_data_q   <= '0;
            credits_q     <= CREDITS_FULL;
            credit_err_q  <= 1'b0;
            flit_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            queue_shift_q <= queue_shift_d;
            link_data_q   <= link_data_d;
            credits_q     <= credits_d;
            credit_err_q  <= credit_err_d;
            flit_count_q  <= flit_count_d;
        end
    end

    assign queue_shift = queue_shift_q;
    assign link_data   = link_data_q;
    assign credits     = credits_q;
    assign credit_err  = credit_err_q;
    assign flit_count  = flit_count_q;
    assign busy        = (state_q != S_IDLE) || head_valid;

endmodule

// File: tb/tb_queue_drain_tx.sv
// Bench for queue_drain_tx: models the input queue, scoreboards transmitted flits
// and checks credit, flush and reset behaviour.
module tb_queue_drain_tx;

    localparam int PL      = 8;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [0:PL-1]    head_data;
    logic             enable;
    logic             flush;
    logic             link_credit;
    logic             queue_shift;
    logic [0:PL-1]    link_data;
    logic [CW-1:0]    credits;
    logic             busy;
    logic             credit_err;
    logic [CNT_W-1:0] flit_count;

    queue_drain_tx #(.PL(PL), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .head_data   (head_data),
        .enable      (enable),
        .flush       (flush),
        .link_credit (link_credit),
        .queue_shift (queue_shift),
        .link_data   (link_data),
        .credits     (credits),
        .busy        (busy),
        .credit_err  (credit_err),
        .flit_count  (flit_count)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [PL-1:0] fifo_q[$];
    logic [PL-1:0] sb_q[$];
    int            pops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void upd_head();
        head_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endfunction

    task automatic push_flit(input logic [PL-1:0] f, input bit expect_tx);
        fifo_q.push_back(f);
        if (expect_tx) sb_q.push_back(f);
        upd_head();
    endtask

    // One clock: outputs are sampled on the falling edge, the queue model shifts on it too.
    task automatic step();
        logic [PL-1:0] exp_f;
        @(negedge clk);
        if (link_data[0]) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_tx", 32'(link_data), 32'h0);
            end else begin
                exp_f = sb_q.pop_front();
                check("sb_flit", 32'(link_data), 32'(exp_f));
                check("sb_shift", 32'(queue_shift), 32'h1);
            end
        end
        if (queue_shift) begin
            pops++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        upd_head();
    endtask

    task automatic credit_pulse();
        link_credit = 1'b1;
        step();
        link_credit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; link_credit = 1'b0;
        upd_head();
        pops = 0;
        step(); step();
        rst = 1'b0;
        step();

        check("rst_shift", 32'(queue_shift), 32'h0);
        check("rst_link", 32'(link_data), 32'h0);
        check("rst_credits", 32'(credits), 32'd4);
        check("rst_count", 32'(flit_count), 32'd0);
        check("rst_err", 32'(credit_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // three flits, back to back
        push_flit(8'h81, 1'b1); push_flit(8'h83, 1'b1); push_flit(8'h85, 1'b1);
        enable = 1'b1;
        step();
        check("b2b_idle_no_pop", 32'(queue_shift), 32'h0);
        step(); check("b2b_f0", 32'(link_data), 32'h81);
        step(); check("b2b_f1", 32'(link_data), 32'h83);
        step(); check("b2b_f2", 32'(link_data), 32'h85);
        step();
        check("b2b_link_idle", 32'(link_data), 32'h0);
        check("b2b_credits", 32'(credits), 32'd1);
        check("b2b_count", 32'(flit_count), 32'd3);
        for (int i = 0; i < 3; i++) credit_pulse();
        step();
        check("b2b_credits_back", 32'(credits), 32'd4);

        // six flits against four credits
        for (int i = 0; i < 6; i++) push_flit(8'(8'h91 + 2 * i), 1'b1);
        for (int i = 0; i < 4; i++) step();
        step();
        check("cr_stall_link", 32'(link_data), 32'h0);
        check("cr_stall_shift", 32'(queue_shift), 32'h0);
        check("cr_stall_credits", 32'(credits), 32'd0);
        credit_pulse();
        check("cr_same_cycle_nosend", 32'(queue_shift), 32'h0);
        step();
        check("cr_5th_sent", 32'(link_data), 32'h99);
        check("cr_5th_credits", 32'(credits), 32'd0);
        credit_pulse();
        check("cr_6th_wait", 32'(link_data), 32'h0);
        step();
        check("cr_6th_sent", 32'(link_data), 32'h9B);
        check("cr_6th_credits", 32'(credits), 32'd0);
        check("cr_count", 32'(flit_count), 32'd9);
        for (int i = 0; i < 4; i++) credit_pulse();
        step();
        check("cr_refill", 32'(credits), 32'd4);
        check("cr_err_clean", 32'(credit_err), 32'h0);

        // spurious credit while full
        credit_pulse();
        step();
        check("sp_credits_hold", 32'(credits), 32'd4);
        check("sp_err_set", 32'(credit_err), 32'h1);

        // flush three queued flits from IDLE
        enable = 1'b0;
        step();
        push_flit(8'hC1, 1'b0); push_flit(8'hC3, 1'b0); push_flit(8'hC5, 1'b0);
        step();
        check("fl_idle_no_pop", 32'(queue_shift), 32'h0);
        check("fl_idle_busy", 32'(busy), 32'h1);
        pops = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_link_zero", 32'(link_data), 32'h0);
        end
        step(); step();
        check("fl_pops", 32'(pops), 32'd3);
        check("fl_credits", 32'(credits), 32'd4);
        check("fl_count", 32'(flit_count), 32'd9);
        check("fl_busy_after", 32'(busy), 32'h0);
        check("fl_err_sticky", 32'(credit_err), 32'h1);

        // reset in the middle of a stream with two credits left
        for (int i = 0; i < 6; i++) push_flit(8'(8'hE1 + 2 * i), i < 2);
        enable = 1'b1;
        step(); step(); step();
        check("mr_credits_pre", 32'(credits), 32'd2);
        rst = 1'b1;
        step();
        check("mr_shift", 32'(queue_shift), 32'h0);
        check("mr_link", 32'(link_data), 32'h0);
        check("mr_credits", 32'(credits), 32'd4);
        check("mr_count", 32'(flit_count), 32'd0);
        check("mr_err", 32'(credit_err), 32'h0);
        enable = 1'b0;
        rst = 1'b0;
        step();
        check("mr_idle_no_pop", 32'(queue_shift), 32'h0);

        // drain leftovers, then an invalid head must never be popped
        pops = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("mr_drain_pops", 32'(pops), 32'd4);
        push_flit(8'h7F, 1'b0);
        enable = 1'b1;
        pops = 0;
        for (int i = 0; i < 4; i++) step();
        check("inv_no_pop", 32'(pops), 32'd0);
        check("inv_credits", 32'(credits), 32'd4);
        check("inv_busy", 32'(busy), 32'h1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
